// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Latency: start at edge 0, done pulse with new HI/LO in cycle WIDTH+2; MTHI/MTLO write at the start edge.
// Backpressure: none; start is ignored while busy, so the hazard unit must hold the request until busy drops.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    // acc holds the 2*WIDTH partial product for multiply; for divide its low
    // half starts as the dividend and is shifted into the quotient bit by bit.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   oper;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   rem;      // partial remainder
    logic [CNTW-1:0]    cnt;
    logic               is_div;
    logic               neg_res;  // sign_a ^ sign_b of the latched operands
    logic               sign_a;
    logic               bzero;

    logic               launch;
    logic               last;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;

    // Iteration datapaths
    logic [WIDTH:0]     msum;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   sub;

    // Sign-corrected results presented at the FINISH edge
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign launch = (state == IDLE) && start && !op[2];
    assign last   = (cnt == CNTW'(WIDTH - 1));

    // op[0] selects the signed variant; -MIN wraps back to MIN, which is 2^(WIDTH-1) unsigned
    assign a_neg  = op[0] && a[WIDTH-1];
    assign b_neg  = op[0] && b[WIDTH-1];
    assign a_abs  = a_neg ? -a : a;
    assign b_abs  = b_neg ? -b : b;

    // Shift-add step: add multiplicand into the upper half when the LSB is set, then shift right
    assign msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, oper} : '0);

    // Restoring divide step: bring the next dividend bit into the remainder and try a subtract.
    // When ge holds the true difference is below 2^WIDTH, so a WIDTH-bit subtract is exact.
    assign shifted = {rem, acc[WIDTH-1]};
    assign ge      = (shifted >= {1'b0, oper});
    assign sub     = shifted[WIDTH-1:0] - oper;

    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = bzero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    // Remainder follows the dividend's sign; for b==0 this restores the original a
    assign rem_fix  = sign_a ? -rem : rem;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and busy flag
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE:    if (launch) state_nxt = RUN;
            RUN:     if (last)   state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, iteration datapath, HI/LO writeback and done/div_zero pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            oper     <= '0;
            rem      <= '0;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            sign_a   <= 1'b0;
            bzero    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= (state == FINISH);
            div_zero <= (state == FINISH) && is_div && bzero;
            case (state)
                IDLE: begin
                    if (start && op == 3'b100) hi <= a;
                    if (start && op == 3'b101) lo <= a;
                    if (launch) begin
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        sign_a  <= a_neg;
                        bzero   <= (b == '0);
                        rem     <= '0;
                        cnt     <= '0;
                        if (op[1]) begin
                            oper <= b_abs;
                            acc  <= {{WIDTH{1'b0}}, a_abs};
                        end else begin
                            oper <= a_abs;
                            acc  <= {{WIDTH{1'b0}}, b_abs};
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + CNTW'(1);
                    if (is_div) begin
                        if (ge) begin
                            rem            <= sub;
                            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b1};
                        end else begin
                            rem            <= shifted[WIDTH-1:0];
                            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= {msum, acc[WIDTH-1:1]};
                    end
                end
                FINISH: begin
                    if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
// Latency: checks done lands in cycle WIDTH+2 after the start edge.
// Backpressure: exercises start-while-busy being ignored and back-to-back starts in the done cycle.
module tb_muldiv_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, div_zero8;
    logic [7:0]  hi8, lo8;

    int tests = 0;
    int fails = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model from the arithmetic definition of each operation
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l, output logic dz);
        logic [63:0] p;
        longint      lx, ly, q, r;
        h = '0; l = '0; dz = 1'b0; p = '0;
        case (o)
            3'b000: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
            3'b001: begin
                lx = longint'($signed(x)); ly = longint'($signed(y));
                p = lx * ly; h = p[63:32]; l = p[31:0];
            end
            3'b010: begin
                if (y == 0) begin l = 32'hFFFFFFFF; h = x; dz = 1'b1; end
                else begin l = x / y; h = x % y; end
            end
            default: begin
                if (y == 0) begin l = 32'hFFFFFFFF; h = x; dz = 1'b1; end
                else begin
                    lx = longint'($signed(x)); ly = longint'($signed(y));
                    q = lx / ly; r = lx % ly;
                    l = q[31:0]; h = r[31:0];
                end
            end
        endcase
    endfunction

    // Issue one arithmetic op from the current negedge (state must be IDLE) and
    // follow it to done. inj>0 fires an MTLO with junk data in that busy cycle.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int inj);
        logic [31:0] eh, el, h0, l0;
        logic        edz;
        int          lat, bad;
        model(o, x, y, eh, el, edz);
        h0 = hi; l0 = lo;
        op = o; a = x; b = y; start = 1'b1;
        lat = 0; bad = 0;
        do begin
            @(negedge clk);
            lat++;
            start = (lat == inj);
            op = 3'b101; a = $urandom; b = $urandom;
            if (!done && (!busy || hi !== h0 || lo !== l0)) bad++;
        end while (!done && lat < 60);
        chk({tag, "_run"}, 64'(bad), 64'd0);
        chk({tag, "_lat"}, 64'(lat), 64'd34);
        chk({tag, "_hi"}, {32'b0, hi}, {32'b0, eh});
        chk({tag, "_lo"}, {32'b0, lo}, {32'b0, el});
        chk({tag, "_dz"}, {63'b0, div_zero}, {63'b0, edz});
        chk({tag, "_busy"}, {63'b0, busy}, 64'd0);
    endtask

    task automatic do_op8(input string tag, input logic [2:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic [7:0] eh, input logic [7:0] el);
        int lat;
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        end while (!done8 && lat < 30);
        chk({tag, "_lat"}, 64'(lat), 64'd10);
        chk({tag, "_hi"}, {56'b0, hi8}, {56'b0, eh});
        chk({tag, "_lo"}, {56'b0, lo8}, {56'b0, el});
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        logic [7:0]  x8, y8;
        logic [15:0] p8;
        int          sel, dcnt;

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_dz", {63'b0, div_zero}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        chk("rst_hilo8", {48'b0, hi8, lo8}, 64'd0);

        // Directed cases; consecutive calls start in the previous done cycle
        do_op("multu", 3'b000, 32'hFFFFFFF0, 32'h7FFFFFF1, 0);
        chk("multu_hi_const", {32'b0, hi}, 64'h7FFFFFE9);
        chk("multu_lo_const", {32'b0, lo}, 64'h000000F0);
        do_op("mult", 3'b001, 32'hFFFFFFF0, 32'h7FFFFFF1, 0);
        chk("mult_hi_const", {32'b0, hi}, 64'hFFFFFFF8);
        do_op("mult_min", 3'b001, 32'h80000000, 32'h80000000, 0);
        chk("mult_min_hi_const", {32'b0, hi}, 64'h40000000);
        do_op("divu", 3'b010, 32'd100, 32'd7, 0);
        chk("divu_lo_const", {32'b0, lo}, 64'h0000000E);
        do_op("div_n7_2", 3'b011, 32'hFFFFFFF9, 32'd2, 0);
        chk("div_n7_2_hi_const", {32'b0, hi}, 64'hFFFFFFFF);
        do_op("div_7_n2", 3'b011, 32'd7, 32'hFFFFFFFE, 0);
        chk("div_7_n2_hi_const", {32'b0, hi}, 64'h00000001);
        do_op("divu_zero", 3'b010, 32'h00001234, 32'd0, 0);
        chk("divu_zero_hi_const", {32'b0, hi}, 64'h00001234);
        @(negedge clk);
        chk("dz_pulse_end", {62'b0, div_zero, done}, 64'd0);
        do_op("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 0);
        chk("div_ovf_lo_const", {32'b0, lo}, 64'h80000000);
        do_op("div_zero_neg", 3'b011, 32'h80000005, 32'd0, 0);

        // MTHI in IDLE
        @(negedge clk);
        op = 3'b100; a = 32'hDEADBEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", {32'b0, hi}, 64'hDEADBEEF);
        chk("mthi_busy", {63'b0, busy}, 64'd0);

        // MTLO while a MULTU is running is ignored
        do_op("multu_mtlo", 3'b000, 32'h00012345, 32'h00000678, 5);

        // Randomised mix including divide-by-zero and MIN/-1 corners
        for (int i = 0; i < 24; i++) begin
            ro  = 3'($urandom_range(0, 3));
            rx  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 15));
                2: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
                3: begin rx = 32'($urandom_range(0, 1000)); ry = $urandom; end
                default: ry = $urandom;
            endcase
            do_op("rand", ro, rx, ry, 0);
        end

        // Reset during cycle 10 of a DIV aborts it
        @(negedge clk);
        op = 3'b011; a = 32'hFFFFFF00; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        do_op("multu_3x5", 3'b000, 32'd3, 32'd5, 0);

        // WIDTH=8 instance
        do_op8("m8_multu", 3'b000, 8'hF0, 8'h71, 8'h69, 8'hF0);
        do_op8("m8_div", 3'b011, 8'hF9, 8'h02, 8'hFF, 8'hFD);
        for (int i = 0; i < 4; i++) begin
            x8 = 8'($urandom); y8 = 8'($urandom);
            p8 = {8'b0, x8} * {8'b0, y8};
            do_op8("m8_rand", 3'b000, x8, y8, p8[15:8], p8[7:0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
